// File: rtl/ram_pkg.sv
// Shared definitions for the pipelined data RAM: access codes, FSM states and
// the per-request pipeline record.
package ram_pkg;

    localparam logic [2:0] ACC_B  = 3'b000;
    localparam logic [2:0] ACC_H  = 3'b001;
    localparam logic [2:0] ACC_W  = 3'b010;
    localparam logic [2:0] ACC_BU = 3'b100;
    localparam logic [2:0] ACC_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic       load;
        logic [1:0] offset;
        logic [2:0] access;
    } pipe_t;

    // Stores have no unsigned variants.
    function automatic logic is_legal_access(input logic store, input logic [2:0] access);
        if (store) begin
            return access inside {ACC_B, ACC_H, ACC_W};
        end
        return access inside {ACC_B, ACC_H, ACC_W, ACC_BU, ACC_HU};
    endfunction

endpackage

// File: rtl/pipelined_data_ram_if.sv
// Request/response bus between the memory stage and the data RAM.
interface pipelined_data_ram_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_access;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_busy;

    modport master (
        output req_valid, req_store, req_access, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

    modport slave (
        input  req_valid, req_store, req_access, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
    );

endinterface

// File: rtl/load_extend.sv
// Lane steering: extends a loaded word (mode 0) or replicates store data and
// builds byte enables (mode 1).
module load_extend
    import ram_pkg::*;
(
    input  logic        mode_i,
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  access_i,
    output logic [31:0] data_o,
    output logic [3:0]  be_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = '0;
        be_o   = '0;
        if (mode_i) begin
            case (access_i)
                ACC_B: begin
                    data_o = {4{word_i[7:0]}};
                    be_o   = 4'b0001 << offset_i;
                end
                ACC_H: begin
                    data_o = {2{word_i[15:0]}};
                    be_o   = offset_i[1] ? 4'b1100 : 4'b0011;
                end
                ACC_W: begin
                    data_o = word_i;
                    be_o   = 4'b1111;
                end
                default: ;
            endcase
        end else begin
            case (access_i)
                ACC_B:   data_o = {{24{byte_sel[7]}}, byte_sel};
                ACC_BU:  data_o = {24'h0, byte_sel};
                ACC_H:   data_o = {{16{half_sel[15]}}, half_sel};
                ACC_HU:  data_o = {16'h0, half_sel};
                ACC_W:   data_o = word_i;
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_data_ram.sv
// Byte-addressed, word-organised data RAM with request checking, a post-reset
// clear sequence and a 1- or 2-cycle response pipeline.
module pipelined_data_ram
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned READ_LATENCY  = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    pipelined_data_ram_if.slave bus
);

    localparam int unsigned Depth = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned IdxW  = ADDR_WIDTH - 2;

    logic [31:0]     mem_q [Depth];
    state_e          state_q;
    logic [IdxW-1:0] cnt_q;
    pipe_t           p1_q;
    logic [31:0]     rdata_q;

    logic            accept, misalign, out_of_range, req_err, store_ok;
    logic [IdxW-1:0] idx;
    logic [31:0]     st_data, ld_data, rsp_data;
    logic [3:0]      st_be, ld_be_unused;

    assign bus.req_ready = (state_q == ST_RUN);
    assign bus.init_busy = (state_q == ST_INIT);
    assign accept        = bus.req_valid & bus.req_ready;
    assign idx           = bus.req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        misalign = ((bus.req_access[1:0] == 2'b01) & bus.req_addr[0]) |
                   ((bus.req_access[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
        out_of_range = (bus.req_addr >> ADDR_WIDTH) != '0;
        req_err      = misalign | out_of_range | !is_legal_access(bus.req_store, bus.req_access);
        store_ok     = accept & bus.req_store & ~req_err;
    end

    load_extend u_store_lanes (
        .mode_i   (1'b1),
        .word_i   (bus.req_wdata),
        .offset_i (bus.req_addr[1:0]),
        .access_i (bus.req_access),
        .data_o   (st_data),
        .be_o     (st_be)
    );

    load_extend u_load_ext (
        .mode_i   (1'b0),
        .word_i   (rdata_q),
        .offset_i (p1_q.offset),
        .access_i (p1_q.access),
        .data_o   (ld_data),
        .be_o     (ld_be_unused)
    );

    // Array has no reset; a reset edge only suppresses writes and reads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (store_ok) begin
                for (int i = 0; i < 4; i++) begin
                    if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
            if (accept) rdata_q <= mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            p1_q    <= '0;
        end else begin
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + IdxW'(1);
                if (cnt_q == IdxW'(Depth - 1)) state_q <= ST_RUN;
            end
            p1_q.valid  <= accept;
            p1_q.err    <= req_err;
            p1_q.load   <= ~bus.req_store;
            p1_q.offset <= bus.req_addr[1:0];
            p1_q.access <= bus.req_access;
        end
    end

    assign rsp_data = (p1_q.valid & ~p1_q.err & p1_q.load) ? ld_data : '0;

    if (READ_LATENCY == 1) begin : gen_lat1
        assign bus.rsp_valid = p1_q.valid;
        assign bus.rsp_err   = p1_q.valid & p1_q.err;
        assign bus.rsp_rdata = rsp_data;
    end else begin : gen_lat2
        logic        rsp_valid_q, rsp_err_q;
        logic [31:0] rsp_rdata_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rsp_valid_q <= 1'b0;
                rsp_err_q   <= 1'b0;
                rsp_rdata_q <= '0;
            end else begin
                rsp_valid_q <= p1_q.valid;
                rsp_err_q   <= p1_q.valid & p1_q.err;
                rsp_rdata_q <= rsp_data;
            end
        end

        assign bus.rsp_valid = rsp_valid_q;
        assign bus.rsp_err   = rsp_err_q;
        assign bus.rsp_rdata = rsp_rdata_q;
    end

endmodule

// File: tb/tb_pipelined_data_ram.sv
// Scoreboard bench: one stimulus stream drives a latency-1 and a latency-2 RAM
// in parallel; each response is checked against a byte-level memory model.
module tb_pipelined_data_ram;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_data_ram_if bus1 ();
    pipelined_data_ram_if bus2 ();

    assign bus2.req_valid  = bus1.req_valid;
    assign bus2.req_store  = bus1.req_store;
    assign bus2.req_access = bus1.req_access;
    assign bus2.req_addr   = bus1.req_addr;
    assign bus2.req_wdata  = bus1.req_wdata;

    pipelined_data_ram #(
        .ADDR_WIDTH    (6),
        .READ_LATENCY  (1),
        .INIT_ON_RESET (1'b1)
    ) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    pipelined_data_ram #(
        .ADDR_WIDTH    (6),
        .READ_LATENCY  (2),
        .INIT_ON_RESET (1'b1)
    ) u_dut_l2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb [2][$];
    logic [31:0] mem_m [16];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic mon(input int k, input int lat, input logic v, input logic [31:0] d,
                       input logic e);
        exp_t x;
        if (v !== 1'b1) return;
        if (sb[k].size() == 0) begin
            check_eq($sformatf("rsp_unexpected_l%0d", lat), 32'(v), 32'd0);
            return;
        end
        x = sb[k].pop_front();
        check_eq($sformatf("rdata_l%0d", lat), d, x.data);
        check_eq($sformatf("err_l%0d", lat), 32'(e), 32'(x.err));
        check_eq($sformatf("latency_l%0d", lat), 32'(cyc - x.cyc), 32'(lat));
    endtask

    always @(negedge clk) begin
        mon(0, 1, bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
        mon(1, 2, bus2.rsp_valid, bus2.rsp_rdata, bus2.rsp_err);
    end

    function automatic logic exp_err(input logic st, input logic [2:0] acc,
                                     input logic [31:0] addr);
        logic illegal, mis;
        illegal = st ? (acc > 3'd2) : !(acc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        case (acc)
            3'd1, 3'd5: mis = addr[0];
            3'd2:       mis = |addr[1:0];
            default:    mis = 1'b0;
        endcase
        return illegal || mis || (addr[31:6] != 26'd0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] acc, input logic [31:0] addr);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = mem_m[addr[5:2]];
        case (addr[1:0])
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = addr[1] ? w[31:16] : w[15:0];
        case (acc)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'h0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] acc, input logic [31:0] addr,
                               input logic [31:0] wd);
        logic [31:0] w;
        w = mem_m[addr[5:2]];
        case (acc)
            3'd0:    w[8*addr[1:0] +: 8] = wd[7:0];
            3'd1:    w[16*addr[1] +: 16] = wd[15:0];
            default: w = wd;
        endcase
        mem_m[addr[5:2]] = w;
    endtask

    task automatic send(input logic st, input logic [2:0] acc, input logic [31:0] addr,
                        input logic [31:0] wd);
        exp_t x;
        logic e;
        bus1.req_valid  = 1'b1;
        bus1.req_store  = st;
        bus1.req_access = acc;
        bus1.req_addr   = addr;
        bus1.req_wdata  = wd;
        check_eq("req_ready_l1", 32'(bus1.req_ready), 32'd1);
        check_eq("req_ready_l2", 32'(bus2.req_ready), 32'd1);
        e      = exp_err(st, acc, addr);
        x.err  = e;
        x.cyc  = cyc;
        x.data = (!e && !st) ? model_load(acc, addr) : 32'd0;
        sb[0].push_back(x);
        sb[1].push_back(x);
        if (!e && st) model_store(acc, addr, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus1.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        bus1.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb[0].delete();
        sb[1].delete();
        check_eq("rst_rsp_valid_l1", 32'(bus1.rsp_valid), 32'd0);
        check_eq("rst_rsp_valid_l2", 32'(bus2.rsp_valid), 32'd0);
        check_eq("rst_rsp_err_l2", 32'(bus2.rsp_err), 32'd0);
        check_eq("rst_rsp_rdata_l1", bus1.rsp_rdata, 32'd0);
        check_eq("rst_rsp_rdata_l2", bus2.rsp_rdata, 32'd0);
        check_eq("rst_init_busy_l1", 32'(bus1.init_busy), 32'd1);
        check_eq("rst_req_ready_l2", 32'(bus2.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_hold_busy_l2", 32'(bus2.init_busy), 32'd1);
        check_eq("rst_hold_ready_l1", 32'(bus1.req_ready), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
        rst = 1'b0;
        // Request presented during the clear must be ignored.
        bus1.req_valid  = 1'b1;
        bus1.req_store  = 1'b1;
        bus1.req_access = 3'd2;
        bus1.req_addr   = 32'h10;
        bus1.req_wdata  = 32'hDEADBEEF;
        n = 0;
        while (bus1.init_busy && n < 100) begin
            check_eq("init_ready_l1", 32'(bus1.req_ready), 32'd0);
            check_eq("init_ready_l2", 32'(bus2.req_ready), 32'd0);
            check_eq("init_busy_l2", 32'(bus2.init_busy), 32'd1);
            @(posedge clk);
            #1;
            n++;
        end
        bus1.req_valid = 1'b0;
        check_eq("init_cycles", 32'(n), 32'd16);
        check_eq("run_ready_l1", 32'(bus1.req_ready), 32'd1);
        check_eq("run_ready_l2", 32'(bus2.req_ready), 32'd1);
        check_eq("run_busy_l2", 32'(bus2.init_busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  accs [6];
        logic [31:0] a;
        accs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        bus1.req_valid  = 1'b0;
        bus1.req_store  = 1'b0;
        bus1.req_access = 3'd0;
        bus1.req_addr   = 32'd0;
        bus1.req_wdata  = 32'd0;
        do_reset();

        send(1'b0, 3'd2, 32'h10, 32'd0);
        send(1'b0, 3'd2, 32'h3C, 32'd0);
        send(1'b0, 3'd2, 32'h00, 32'd0);

        send(1'b1, 3'd2, 32'h10, 32'h80FF7F01);
        send(1'b0, 3'd0, 32'h10, 32'd0);
        send(1'b0, 3'd0, 32'h11, 32'd0);
        send(1'b0, 3'd4, 32'h11, 32'd0);
        send(1'b0, 3'd0, 32'h12, 32'd0);
        send(1'b0, 3'd4, 32'h12, 32'd0);
        send(1'b0, 3'd1, 32'h12, 32'd0);
        send(1'b0, 3'd5, 32'h12, 32'd0);
        send(1'b0, 3'd1, 32'h10, 32'd0);
        send(1'b0, 3'd2, 32'h10, 32'd0);

        send(1'b1, 3'd2, 32'h20, 32'h11223344);
        send(1'b1, 3'd0, 32'h21, 32'h000000AA);
        send(1'b0, 3'd2, 32'h20, 32'd0);
        send(1'b1, 3'd2, 32'h30, 32'hCAFEF00D);
        send(1'b0, 3'd2, 32'h30, 32'd0);
        send(1'b1, 3'd1, 32'h32, 32'h0000BEEF);
        send(1'b0, 3'd2, 32'h30, 32'd0);
        send(1'b0, 3'd5, 32'h32, 32'd0);
        idle(2);

        send(1'b0, 3'd1, 32'h03, 32'd0);
        send(1'b1, 3'd2, 32'h22, 32'hFFFFFFFF);
        send(1'b0, 3'd2, 32'h40, 32'd0);
        send(1'b0, 3'd3, 32'h00, 32'd0);
        send(1'b1, 3'd4, 32'h20, 32'hFFFFFFFF);
        send(1'b1, 3'd2, 32'h60, 32'h55555555);
        send(1'b0, 3'd2, 32'h20, 32'd0);
        send(1'b0, 3'd2, 32'h00, 32'd0);

        for (int i = 0; i < 32; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h40;
            send(1'($urandom_range(0, 1)), accs[$urandom_range(0, 5)], a, $urandom);
        end
        idle(4);

        send(1'b1, 3'd2, 32'h10, 32'h12345678);
        send(1'b0, 3'd2, 32'h10, 32'd0);
        send(1'b0, 3'd2, 32'h20, 32'd0);
        do_reset();
        send(1'b0, 3'd2, 32'h10, 32'd0);
        send(1'b0, 3'd2, 32'h20, 32'd0);
        idle(4);

        check_eq("drain_l1", 32'(sb[0].size()), 32'd0);
        check_eq("drain_l2", 32'(sb[1].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
